// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if: EX-stage <-> HI/LO sequencer bus.
//
// Purpose: bundles the request side (start/op/operands/rd_hilo/flush) and the
// response side (ready/busy/stall and the HI/LO write port) of muldiv_seq.
//
// Signals (master = EX stage, slave = muldiv_seq):
//   start    m->s  1   HI/LO operation presented this cycle
//   op       m->s  3   operation code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a_in     m->s  32  operand A (rs)
//   b_in     m->s  32  operand B (rt)
//   rd_hilo  m->s  1   MFHI/MFLO executing this cycle
//   flush    m->s  1   cancel in-flight operation
//   ready    s->m  1   sequencer idle, can accept
//   busy     s->m  1   sequencer not idle
//   stall    s->m  1   pipeline freeze request
//   hilo_we  s->m  1   one-cycle HI/LO write strobe
//   hilo_op  s->m  3   latched op
//   hilo_a   s->m  32  latched operand A
//   hilo_b   s->m  32  latched operand B
//   dz_err   s->m  1   divide-by-zero pulse (MULDIV_DIV0_CHECK_EN builds only)
// -----------------------------------------------------------------------------
`ifndef MULT
`define MULT  3'b000
`endif
`ifndef MULTU
`define MULTU 3'b001
`endif
`ifndef DIV
`define DIV   3'b010
`endif
`ifndef DIVU
`define DIVU  3'b011
`endif
`ifndef MTHI
`define MTHI  3'b100
`endif
`ifndef MTLO
`define MTLO  3'b101
`endif

interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        rd_hilo;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        stall;
  logic        hilo_we;
  logic [2:0]  hilo_op;
  logic [31:0] hilo_a;
  logic [31:0] hilo_b;
  logic        dz_err;

  modport master (
    output start, op, a_in, b_in, rd_hilo, flush,
    input  ready, busy, stall, hilo_we, hilo_op, hilo_a, hilo_b, dz_err
  );

  modport slave (
    input  start, op, a_in, b_in, rd_hilo, flush,
    output ready, busy, stall, hilo_we, hilo_op, hilo_a, hilo_b, dz_err
  );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq: sequencer in front of the HI/LO multiply/divide unit (EX stage).
//
// Models the multi-cycle latency of MULT/MULTU/DIV/DIVU, holds the operands
// stable while an operation runs, issues exactly one hilo_we per accepted
// operation and requests a pipeline stall for a new HI/LO operation or an
// MFHI/MFLO while a result is pending.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of muldiv_if (request/response signals, see muldiv_if)
//
// Parameters:
//   MUL_LAT  busy cycles for MULT/MULTU before write-back (1..63)
//   DIV_LAT  busy cycles for DIV/DIVU before write-back (1..63)
//
// Optional feature macro: MULDIV_DIV0_CHECK_EN
//   defined     : DIV/DIVU with b_in==0 pulses dz_err one cycle after accept
//                 and returns straight to IDLE with no write.
//   not defined : divide by zero is sequenced like any divide, dz_err = 0.
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_e;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        dz_q, dz_d;

  logic ready;
  logic accept;
  logic is_mt, is_mul, is_div;

  assign ready  = (state_q == IDLE);
  assign accept = bus.start && ready && !bus.flush;

  assign is_mt  = (bus.op == `MTHI)  || (bus.op == `MTLO);
  assign is_mul = (bus.op == `MULT)  || (bus.op == `MULTU);
  assign is_div = (bus.op == `DIV)   || (bus.op == `DIVU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Unknown op codes are dropped without touching the latched operands.
        if (accept && (is_mt || is_mul || is_div)) begin
          op_d = bus.op;
          a_d  = bus.a_in;
          b_d  = bus.b_in;
          if (is_mt) begin
            state_d = WRITE;
          end else if (is_mul) begin
            state_d = RUN;
            cnt_d   = MUL_CNT;
          end else begin
`ifdef MULDIV_DIV0_CHECK_EN
            if (bus.b_in == 32'd0) begin
              dz_d    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RUN;
              cnt_d   = DIV_CNT;
            end
`else
            state_d = RUN;
            cnt_d   = DIV_CNT;
`endif
          end
        end
      end
      RUN: begin
        // Flush abandons the result; the stale operands stay latched.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      WRITE: begin
        // Committed: flush has no effect here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready   = ready;
  assign bus.busy    = !ready;
  // HI/LO still hold old values during WRITE, so reads stall through it.
  assign bus.stall   = (bus.start && !ready) || (bus.rd_hilo && !ready);
  assign bus.hilo_we = (state_q == WRITE);
  assign bus.hilo_op = op_q;
  assign bus.hilo_a  = a_q;
  assign bus.hilo_b  = b_q;
  assign bus.dz_err  = dz_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Sequencer in front of the HI/LO multiply/divide unit in the EX stage.
- Models the multi-cycle latency of MULT/MULTU/DIV/DIVU and holds operands stable while an operation runs.
- Issues exactly one hilo_we pulse per accepted operation.
- Stalls the pipeline when it issues a new HI/LO operation or reads HI/LO (MFHI/MFLO) while a result is still pending.

Parameters:
MUL_LAT, 4, busy cycles for MULT/MULTU before write-back (legal range 1..63)
DIV_LAT, 32, busy cycles for DIV/DIVU before write-back (legal range 1..63)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  EX stage presents a HI/LO operation this cycle
op  in  3  operation code; uses the `MULT/`MULTU/`DIV/`DIVU/`MTHI/`MTLO macros from public.v
a_in  in  32  operand A (rs)
b_in  in  32  operand B (rt)
rd_hilo  in  1  EX stage executes MFHI/MFLO this cycle
flush  in  1  cancels the in-flight operation (exception or branch squash)
ready  out  1  high only in IDLE; start is accepted when start&&ready&&!flush
busy  out  1  state != IDLE
stall  out  1  pipeline freeze request
hilo_we  out  1  one-cycle write strobe to the HI/LO unit
hilo_op  out  3  latched op, driven to the HI/LO unit
hilo_a  out  32  latched operand A
hilo_b  out  32  latched operand B
dz_err  out  1  one-cycle pulse: divide by zero detected (optional feature only)

Behaviour:
- States: IDLE, RUN, WRITE. 6-bit down-counter cnt.
- Reset, async on rst_n low:
  - state=IDLE, cnt=0.
  - All outputs 0: hilo_we, hilo_op, hilo_a, hilo_b, dz_err, busy, stall. ready=1.
  - Reset mid-RUN or mid-WRITE abandons the operation with no write.
- IDLE with accept:
  - Latch op/a_in/b_in into hilo_op/hilo_a/hilo_b.
  - MTHI/MTLO -> WRITE.
  - MULT/MULTU -> RUN, cnt=MUL_LAT-1.
  - DIV/DIVU -> RUN, cnt=DIV_LAT-1.
  - Undefined op code: ignored, stays IDLE.
- RUN:
  - cnt decrements each cycle; when cnt==0, next state is WRITE.
  - flush in RUN -> IDLE, no write; latched operands are kept but unused.
- WRITE:
  - hilo_we=1 for exactly this cycle; next state is IDLE.
  - flush is ignored (the operation is committed).
- hilo_we is combinational from state==WRITE. hilo_op/hilo_a/hilo_b are stable from the cycle after accept until leaving WRITE.
- Latency from the accept cycle (cycle 0):
  - MULT/MULTU: hilo_we in cycle MUL_LAT+1.
  - DIV/DIVU: hilo_we in cycle DIV_LAT+1.
  - MTHI/MTLO: hilo_we in cycle 1.
- stall, combinational: (start && !ready) || (rd_hilo && state!=IDLE).
  - In WRITE, HI/LO still hold old values, so reads stall through the WRITE cycle.
  - Reads in IDLE never stall.
- Simultaneous events:
  - start and flush in IDLE: flush wins, nothing accepted, no stall.
  - start and rd_hilo: stall is the OR of both terms.
- No back-to-back acceptance: a start in WRITE is stalled and accepted in the following IDLE cycle.
- Operand arithmetic is not performed here; widths pass through unchanged.

Optional Feature:
Macro MULDIV_DIV0_CHECK_EN.
- Defined: at accept of DIV/DIVU with b_in==0:
  - dz_err pulses 1 in cycle 1.
  - State goes directly to IDLE; no RUN, no hilo_we; HI/LO are unchanged.
  - ready is high again in cycle 1.
- Not defined: divide by zero is sequenced like any DIV (RUN then WRITE; HI/LO result architecturally undefined) and dz_err is tied 0.

Test Plan:
1. Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately, ready=1; release, start=0 for 10 cycles -> hilo_we never asserts.
2. MULT a=3 b=-2 accepted cycle 0 (MUL_LAT=4):
   - busy in cycles 1..5; hilo_we=1 only in cycle 5; hilo_op=`MULT, hilo_a=3, hilo_b=0xFFFFFFFE.
   - rd_hilo in cycle 3 -> stall=1; rd_hilo in cycle 6 -> stall=0.
3. DIVU a=100 b=7 (DIV_LAT=32), second start (MTLO a=5) presented from cycle 2:
   - stall=1 cycles 2..33; DIVU hilo_we in cycle 33.
   - MTLO accepted cycle 34; its hilo_we in cycle 35 with hilo_a=5.
4. DIV started cycle 0, flush in cycle 10 -> IDLE in cycle 11, no hilo_we; flush asserted in a WRITE cycle -> hilo_we still 1.
5. start and flush together in IDLE with MTHI -> not accepted, hilo_we stays 0, stall=0.
6. Optional feature:
   - With MULDIV_DIV0_CHECK_EN: DIV b=0 -> dz_err=1 in cycle 1, no hilo_we, ready=1 in cycle 1.
   - Without it: hilo_we in cycle DIV_LAT+1, dz_err=0.
